// File: rtl/dsp_mac_lane_pkg.sv
// Shared types and default sizing for the DSP MAC lane used in Montgomery PE columns.
package dsp_mac_lane_pkg;

    localparam int DEF_K       = 17;
    localparam int DEF_L       = 26;
    localparam int DEF_ACC_W   = 48;
    localparam int DEF_LATENCY = 3;
    localparam int DEF_SHIFT   = 17;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'd0,
        MODE_MULADD = 2'd1,
        MODE_PE     = 2'd2,
        MODE_PE_SH  = 2'd3
    } mode_t;

    // Control that travels alongside each beat down the pipeline.
    typedef struct packed {
        mode_t mode;
        logic  first;
        logic  last;
    } beat_tag_t;

endpackage

// File: rtl/dsp_mac_lane_if.sv
// Beat-in / result-out stream bundle of one MAC lane; master is the column controller.
interface dsp_mac_lane_if
    import dsp_mac_lane_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int L     = DEF_L,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT
);

    logic             in_valid;
    logic             in_ready;
    mode_t            in_mode;
    logic             in_first;
    logic             in_last;
    logic [L-1:0]     in_a;
    logic [K-1:0]     in_b;
    logic [L-1:0]     in_m;
    logic [K-1:0]     in_q;
    logic [ACC_W-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_s;
    logic [SHIFT-1:0] out_limb;
    logic             out_last;

    modport master (
        output in_valid, in_mode, in_first, in_last, in_a, in_b, in_m, in_q, in_c, out_ready,
        input  in_ready, out_valid, out_s, out_limb, out_last
    );

    modport slave (
        input  in_valid, in_mode, in_first, in_last, in_a, in_b, in_m, in_q, in_c, out_ready,
        output in_ready, out_valid, out_s, out_limb, out_last
    );

endinterface

// File: rtl/dsp_mac_lane_pipe_reg.sv
// Stall-enabled register slice (data + valid); one instance per pipeline stage.
module dsp_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // NOTE: data is reset together with valid so a freshly reset lane never
    // presents stale operands; the slices are plain flops, so this is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every slice samples its neighbour's pre-edge value.
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/dsp_mac_lane.sv
// Run-time selectable DSP48-style MAC lane: LATENCY-deep stallable pipe ending in a burst accumulator.
module dsp_mac_lane
    import dsp_mac_lane_pkg::*;
#(
    parameter int K       = DEF_K,
    parameter int L       = DEF_L,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int SHIFT   = DEF_SHIFT
) (
    input logic            clk,
    input logic            rst_n,
    dsp_mac_lane_if.slave  bus
);

    if (LATENCY < 2 || LATENCY > 6) begin : g_latency_check
        $error("dsp_mac_lane: LATENCY must be within 2..6");
    end

    localparam int TAG_W = $bits(beat_tag_t);
    localparam int S1_W  = TAG_W + 2 * L + 2 * K + ACC_W;
    localparam int P_W   = TAG_W + ACC_W;
    localparam int NP    = LATENCY - 1;  // raw-term taps: combinational head plus LATENCY-2 regs

    logic             stall;
    logic             en;
    logic             acc_valid;
    logic             acc_last;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    assign stall = acc_valid && !bus.out_ready;
    assign en    = !stall;

    // Stage 1: register operands and tag.
    beat_tag_t        in_tag;
    logic             s1_valid;
    logic [S1_W-1:0]  s1_data;
    beat_tag_t        s1_tag;
    logic [L-1:0]     s1_a;
    logic [L-1:0]     s1_m;
    logic [K-1:0]     s1_b;
    logic [K-1:0]     s1_q;
    logic [ACC_W-1:0] s1_c;

    assign in_tag = '{mode: bus.in_mode, first: bus.in_first, last: bus.in_last};

    dsp_pipe_reg #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (bus.in_valid),
        .in_data   ({in_tag, bus.in_a, bus.in_b, bus.in_m, bus.in_q, bus.in_c}),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    assign {s1_tag, s1_a, s1_b, s1_m, s1_q, s1_c} = s1_data;

    // Raw term; the trailing register chain lets synthesis retime the multipliers into DSP stages.
    logic [ACC_W-1:0] ab;
    logic [ACC_W-1:0] mq;
    logic [ACC_W-1:0] p_raw;

    assign ab = ACC_W'(s1_a) * ACC_W'(s1_b);
    assign mq = ACC_W'(s1_m) * ACC_W'(s1_q);

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        p_raw = ab;
        case (s1_tag.mode)
            MODE_MULADD: p_raw = ab + s1_c;
            MODE_PE:     p_raw = ab + mq + s1_c;
            MODE_PE_SH:  p_raw = ab + mq;
            default:     p_raw = ab;
        endcase
    end

    logic [P_W-1:0] p_data [NP];
    logic [NP-1:0]  p_valid;

    assign p_data[0]  = {s1_tag, p_raw};
    assign p_valid[0] = s1_valid;

    for (genvar i = 1; i < NP; i++) begin : g_p_stage
        dsp_pipe_reg #(.W(P_W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (p_valid[i-1]),
            .in_data   (p_data[i-1]),
            .out_valid (p_valid[i]),
            .out_data  (p_data[i])
        );
    end

    // Accumulator stage.
    beat_tag_t        t_tag;
    logic [ACC_W-1:0] t_p;
    logic             t_valid;

    assign {t_tag, t_p} = p_data[NP-1];
    assign t_valid      = p_valid[NP-1];

    always_comb begin
        acc_next = acc;
        if (t_tag.first)                   acc_next = t_p;
        else if (t_tag.mode == MODE_PE_SH) acc_next = t_p + (acc >> SHIFT);
        else                               acc_next = acc + t_p;
    end

    // acc resets to 0, so the first beat after reset lands as p whatever its first flag says.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
            acc       <= '0;
        end else if (en) begin
            acc_valid <= t_valid;
            if (t_valid) begin
                acc      <= acc_next;
                acc_last <= t_tag.last;
            end
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = acc_valid;
    assign bus.out_s     = acc;
    assign bus.out_limb  = acc[SHIFT-1:0];
    assign bus.out_last  = acc_last;

endmodule

// File: tb/tb_dsp_mac_lane.sv
// Directed bench for dsp_mac_lane at default sizing (LATENCY=3).
module tb_dsp_mac_lane;
    import dsp_mac_lane_pkg::*;

    localparam int K       = 17;
    localparam int L       = 26;
    localparam int ACC_W   = 48;
    localparam int LATENCY = 3;
    localparam int SHIFT   = 17;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    dsp_mac_lane_if #(.K(K), .L(L), .ACC_W(ACC_W), .SHIFT(SHIFT)) bus ();

    dsp_mac_lane #(.K(K), .L(L), .ACC_W(ACC_W), .LATENCY(LATENCY), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mode_t mode, input logic first, input logic last,
                         input logic [L-1:0] a, input logic [K-1:0] b,
                         input logic [L-1:0] m, input logic [K-1:0] q,
                         input logic [ACC_W-1:0] c);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_m     = m;
        bus.in_q     = q;
        bus.in_c     = c;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_mode   = MODE_MUL;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_m      = '0;
        bus.in_q      = '0;
        bus.in_c      = '0;
        idle();
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_s", 64'(bus.out_s), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Three beats in flight, then asynchronous reset mid-stream.
        drive(MODE_MUL, 1'b1, 1'b1, 26'd10, 17'd10, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MUL, 1'b1, 1'b1, 26'd11, 17'd11, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MUL, 1'b1, 1'b1, 26'd12, 17'd12, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        check("pre_rst_out_s", 64'(bus.out_s), 64'd100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_s", 64'(bus.out_s), 64'd0);
        tick();
        rst_n = 1'b1;

        // First post-reset beat without in_first: lands exactly LATENCY cycles later.
        drive(MODE_MUL, 1'b0, 1'b1, 26'd3, 17'd5, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        check("lat_c1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_c2_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_c3_valid", 64'(bus.out_valid), 64'd1);
        check("lat_c3_out_s", 64'(bus.out_s), 64'd15);
        tick();
        check("lat_drained", 64'(bus.out_valid), 64'd0);

        // Modes back to back, single-beat bursts.
        drive(MODE_MUL, 1'b1, 1'b1, 26'h3FF_FFFF, 17'h1_FFFF, 26'd9, 17'd9, 48'd55);
        tick();
        drive(MODE_MULADD, 1'b1, 1'b1, 26'd7, 17'd9, 26'd0, 17'd0, 48'd100);
        tick();
        drive(MODE_PE, 1'b1, 1'b1, 26'd2, 17'd3, 26'd4, 17'd5, 48'd1);
        tick();
        idle();
        check("mul_max", 64'(bus.out_s), 64'd8796025782273);
        check("mul_max_last", 64'(bus.out_last), 64'd1);
        tick();
        check("muladd_valid", 64'(bus.out_valid), 64'd1);
        check("muladd", 64'(bus.out_s), 64'd163);
        tick();
        check("pe_valid", 64'(bus.out_valid), 64'd1);
        check("pe", 64'(bus.out_s), 64'd27);
        tick();
        check("modes_drained", 64'(bus.out_valid), 64'd0);

        // MULADD accumulate burst, back to back.
        drive(MODE_MULADD, 1'b1, 1'b0, 26'd1, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MULADD, 1'b0, 1'b0, 26'd2, 17'd2, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MULADD, 1'b0, 1'b1, 26'd3, 17'd3, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        check("burst_b1", 64'(bus.out_s), 64'd1);
        check("burst_b1_last", 64'(bus.out_last), 64'd0);
        tick();
        check("burst_b2", 64'(bus.out_s), 64'd5);
        check("burst_b2_last", 64'(bus.out_last), 64'd0);
        tick();
        check("burst_b3", 64'(bus.out_s), 64'd14);
        check("burst_b3_last", 64'(bus.out_last), 64'd1);
        tick();

        // Same burst with a 2-cycle bubble after the first beat.
        drive(MODE_MULADD, 1'b1, 1'b0, 26'd1, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        tick();
        tick();
        check("bub_b1", 64'(bus.out_s), 64'd1);
        drive(MODE_MULADD, 1'b0, 1'b0, 26'd2, 17'd2, 26'd0, 17'd0, 48'd0);
        tick();
        check("bub_gap_valid", 64'(bus.out_valid), 64'd0);
        check("bub_gap_hold", 64'(bus.out_s), 64'd1);
        drive(MODE_MULADD, 1'b0, 1'b1, 26'd3, 17'd3, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        check("bub_gap2_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("bub_b2", 64'(bus.out_s), 64'd5);
        tick();
        check("bub_b3", 64'(bus.out_s), 64'd14);
        check("bub_b3_last", 64'(bus.out_last), 64'd1);
        tick();

        // PE_SH carry chain; addend must be ignored in this mode.
        drive(MODE_PE_SH, 1'b1, 1'b0, 26'd1048581, 17'd1, 26'd0, 17'd0, 48'd1000);
        tick();
        drive(MODE_PE_SH, 1'b0, 1'b1, 26'd0, 17'd0, 26'd1, 17'd1, 48'd1000);
        tick();
        idle();
        tick();
        check("pesh_b1", 64'(bus.out_s), 64'd1048581);
        check("pesh_b1_limb", 64'(bus.out_limb), 64'd5);
        tick();
        check("pesh_b2", 64'(bus.out_s), 64'd9);
        check("pesh_b2_limb", 64'(bus.out_limb), 64'd9);
        tick();

        // Backpressure with LATENCY beats in flight and a fourth waiting.
        drive(MODE_MUL, 1'b1, 1'b1, 26'd10, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MUL, 1'b1, 1'b1, 26'd20, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MUL, 1'b1, 1'b1, 26'd30, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        drive(MODE_MUL, 1'b1, 1'b1, 26'd40, 17'd1, 26'd0, 17'd0, 48'd0);
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_hold_s_%0d", i), 64'(bus.out_s), 64'd10);
            check($sformatf("bp_hold_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold_ready_%0d", i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        idle();
        check("bp_r2", 64'(bus.out_s), 64'd20);
        tick();
        check("bp_r3", 64'(bus.out_s), 64'd30);
        tick();
        check("bp_r4", 64'(bus.out_s), 64'd40);
        check("bp_r4_valid", 64'(bus.out_valid), 64'd1);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Wrap modulo 2^ACC_W.
        drive(MODE_MULADD, 1'b1, 1'b0, 26'd0, 17'd0, 26'd0, 17'd0, 48'hFFFF_FFFF_FFFF);
        tick();
        drive(MODE_MULADD, 1'b0, 1'b1, 26'd1, 17'd1, 26'd0, 17'd0, 48'd0);
        tick();
        idle();
        tick();
        check("wrap_b1", 64'(bus.out_s), 64'hFFFF_FFFF_FFFF);
        tick();
        check("wrap_b2", 64'(bus.out_s), 64'd0);
        check("wrap_b2_last", 64'(bus.out_last), 64'd1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_lane.md
Name: dsp_mac_lane

Overview:
- Parametrised, vendor-IP-free successor to the fixed-latency DSP wrappers (mul / muladd / PE / PE_24).
- Computes one of four DSP48-style products per beat, selected at run time, through a LATENCY-stage stallable pipeline.
- The final stage holds a burst accumulator with optional right-shift carry propagation between beats.
- Sits inside Montgomery PE columns: one instance per column replaces the separate mul and PE instances.

Parameters:
- K, 17, width of in_b and in_q (DSP B-port operand width).
- L, 26, width of in_a and in_m (DSP A-port operand width).
- ACC_W, 48, accumulator and output width (DSP P width).
- LATENCY, 3, cycles from accepted input to out_valid with no stall. Legal range 2..6; any other value is an elaboration error.
- SHIFT, 17, right shift applied to the previous accumulator in accumulate-with-shift beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  lane can accept a beat
- in_mode  in  2  operation select: 0 MUL, 1 MULADD, 2 PE, 3 PE_SH
- in_first  in  1  first beat of a burst; the accumulator is restarted
- in_last  in  1  last beat of a burst
- in_a  in  L  multiplicand A
- in_b  in  K  multiplier B
- in_m  in  L  modulus limb M
- in_q  in  K  quotient digit Q
- in_c  in  ACC_W  addend C
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_s  out  ACC_W  accumulated result
- out_limb  out  SHIFT  out_s[SHIFT-1:0]
- out_last  out  1  in_last tag of this result

Behaviour:
- Reset (asynchronous): all valid bits 0, accumulator 0, out_s 0, out_last 0, out_valid 0. in_ready is 1 once reset deasserts.
- Handshake: a beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Stall is global: stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every pipeline register, valid bit and the accumulator hold.
  - out_s, out_limb and out_last are stable while out_valid && !out_ready.
- Pipeline: valid/tag shift register of depth LATENCY.
  - Stages 1..LATENCY-1 compute the raw term p.
  - Stage LATENCY is the accumulator stage and drives the outputs.
  - Throughput is one beat per cycle when out_ready is held high.
- Raw term by mode; all operands unsigned, zero-extended to ACC_W, arithmetic modulo 2^ACC_W:
  - MUL: p = a*b
  - MULADD: p = a*b + c
  - PE: p = a*b + m*q + c
  - PE_SH: p = a*b + m*q
- Accumulator stage:
  - first beat: acc = p.
  - non-first, mode != PE_SH: acc = acc + p.
  - non-first, mode PE_SH: acc = p + (acc >> SHIFT). This is limb carry propagation, logical shift.
- out_s = acc after the update. out_valid is asserted for every beat, not only the last. out_last follows the tag.
- Beat without in_first after reset: accumulates onto 0.
- Bubbles (in_valid=0) between beats of a burst do not disturb acc.
- in_first && in_last: single-beat burst, out_s = p.
- Mode may change beat to beat; each beat uses its own tagged mode.
- Reset mid-burst discards all in-flight beats. The next accepted beat behaves as first regardless of in_first.

Decomposition:
- Shared package (PARAMS_BN254_d0 or sibling) holds:
  - mode_t enum {MODE_MUL, MODE_MULADD, MODE_PE, MODE_PE_SH}.
  - default K, L, ACC_W constants.
  - a beat_tag_t struct {mode, first, last}.
- One natural sub-module, dsp_pipe_reg: a stall-enabled, async-reset register slice (data + valid). It is instantiated per stage so that the product depth scales with LATENCY. The multiplier is inferred for DSP retiming.

Test Plan:
- Reset: rst_n low mid-stream with 3 beats in flight -> out_valid=0, out_s=0 immediately. First post-reset beat MUL a=3,b=5 -> out_s=15 exactly LATENCY cycles after acceptance.
- Modes, back-to-back, out_ready=1, single-beat bursts:
  - MUL a=2^26-1, b=2^17-1 -> out_s=(2^26-1)(2^17-1).
  - MULADD a=7, b=9, c=100 -> 163.
  - PE a=2, b=3, m=4, q=5, c=1 -> 27.
  - Results arrive on consecutive cycles.
- Accumulate burst, MULADD:
  - (a=1,b=1,c=0,first), (a=2,b=2,c=0), (a=3,b=3,c=0,last) -> out_s 1, 5, 14.
  - out_last only on 14.
  - Insert a 2-cycle in_valid bubble mid-burst -> same values.
- PE_SH carry chain:
  - first beat p=2^20+5 -> out_s=2^20+5, out_limb=5.
  - next beat p=1 -> out_s=1+(2^20+5>>17)=9.
- Backpressure: out_ready low 4 cycles with LATENCY beats in flight -> in_ready=0, outputs frozen, no beat lost or duplicated. Sequence order preserved after release.
- Wrap: MULADD first a=0, b=0, c=2^48-1, then a=1, b=1, c=0 -> out_s=0 (mod 2^48).
